// File: rtl/axi_rd_arb_pkg.sv
// Shared AXI widths, response codes and arbiter FSM encoding for the read arbiter.
package axi_rd_arb_pkg;

    localparam int unsigned AxiIdWidth    = 4;
    localparam int unsigned AxiAddrWidth  = 32;
    localparam int unsigned AxiDataWidth  = 32;
    localparam int unsigned AxiUserWidth  = 4;
    localparam int unsigned AxiLenWidth   = 8;
    localparam int unsigned AxiSizeWidth  = 3;
    localparam int unsigned AxiBurstWidth = 2;
    localparam int unsigned AxiRespWidth  = 2;

    localparam logic [AxiRespWidth-1:0] AxiRespOkay   = 2'b00;
    localparam logic [AxiRespWidth-1:0] AxiRespSlverr = 2'b10;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAddr = 2'd1,
        StData = 2'd2
    } arb_state_e;

endpackage

// File: rtl/axi_rd_arb_rr_arb2.sv
// Two-requester round-robin picker: a lone requester wins, a tie goes to the
// requester that did not win last time.
module axi_rd_arb_rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic       gnt_o
);

    // Pure combinational pick; the caller registers the result
    always_comb begin
        gnt_o = 1'b0;
        unique case (req_i)
            2'b01:   gnt_o = 1'b0;
            2'b10:   gnt_o = 1'b1;
            2'b11:   gnt_o = ~last_grant_i;
            default: gnt_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/axi_rd_arb.sv
// 2:1 AXI read arbiter. One transaction in flight; ownership is held from the
// AR handshake until the R beat carrying rlast. Misplaced rlast sets a sticky flag.
module axi_rd_arb
    import axi_rd_arb_pkg::*;
#(
    parameter int unsigned ID_W   = AxiIdWidth,
    parameter int unsigned ADDR_W = AxiAddrWidth,
    parameter int unsigned DATA_W = AxiDataWidth,
    parameter int unsigned USER_W = AxiUserWidth
) (
    input  logic                     clk,
    input  logic                     rst,
    // master 0
    input  logic [ID_W-1:0]          m0_arid,
    input  logic [ADDR_W-1:0]        m0_araddr,
    input  logic [AxiLenWidth-1:0]   m0_arlen,
    input  logic [AxiSizeWidth-1:0]  m0_arsize,
    input  logic [AxiBurstWidth-1:0] m0_arburst,
    input  logic [USER_W-1:0]        m0_aruser,
    input  logic                     m0_arvalid,
    output logic                     m0_arready,
    output logic [ID_W-1:0]          m0_rid,
    output logic [DATA_W-1:0]        m0_rdata,
    output logic [AxiRespWidth-1:0]  m0_rresp,
    output logic                     m0_rlast,
    output logic [USER_W-1:0]        m0_ruser,
    output logic                     m0_rvalid,
    input  logic                     m0_rready,
    // master 1
    input  logic [ID_W-1:0]          m1_arid,
    input  logic [ADDR_W-1:0]        m1_araddr,
    input  logic [AxiLenWidth-1:0]   m1_arlen,
    input  logic [AxiSizeWidth-1:0]  m1_arsize,
    input  logic [AxiBurstWidth-1:0] m1_arburst,
    input  logic [USER_W-1:0]        m1_aruser,
    input  logic                     m1_arvalid,
    output logic                     m1_arready,
    output logic [ID_W-1:0]          m1_rid,
    output logic [DATA_W-1:0]        m1_rdata,
    output logic [AxiRespWidth-1:0]  m1_rresp,
    output logic                     m1_rlast,
    output logic [USER_W-1:0]        m1_ruser,
    output logic                     m1_rvalid,
    input  logic                     m1_rready,
    // slave
    output logic [ID_W-1:0]          s_arid,
    output logic [ADDR_W-1:0]        s_araddr,
    output logic [AxiLenWidth-1:0]   s_arlen,
    output logic [AxiSizeWidth-1:0]  s_arsize,
    output logic [AxiBurstWidth-1:0] s_arburst,
    output logic [USER_W-1:0]        s_aruser,
    output logic                     s_arvalid,
    input  logic                     s_arready,
    input  logic [ID_W-1:0]          s_rid,
    input  logic [DATA_W-1:0]        s_rdata,
    input  logic [AxiRespWidth-1:0]  s_rresp,
    input  logic                     s_rlast,
    input  logic [USER_W-1:0]        s_ruser,
    input  logic                     s_rvalid,
    output logic                     s_rready,
    // status
    output logic                     grant,
    output logic                     busy,
    output logic                     len_err
);

    arb_state_e             state_q;
    logic                   grant_q;
    logic                   last_grant_q;
    logic                   len_err_q;
    logic [AxiLenWidth-1:0] len_q;
    logic [AxiLenWidth:0]   beat_cnt_q;

    logic pick;
    logic gnt_arvalid;
    logic gnt_rready;
    logic in_addr;
    logic in_data;
    logic r_hs;
    logic at_len;

    axi_rd_arb_rr_arb2 u_rr_arb2 (
        .req_i        ({m1_arvalid, m0_arvalid}),
        .last_grant_i (last_grant_q),
        .gnt_o        (pick)
    );

    assign in_addr     = (state_q == StAddr);
    assign in_data     = (state_q == StData);
    assign gnt_arvalid = grant_q ? m1_arvalid : m0_arvalid;
    assign gnt_rready  = grant_q ? m1_rready : m0_rready;
    assign r_hs        = s_rvalid & s_rready;
    assign at_len      = (beat_cnt_q == {1'b0, len_q});

    assign grant   = grant_q;
    assign busy    = (state_q != StIdle);
    assign len_err = len_err_q;

    // AR path: granted master's request muxed onto the slave, handshakes only in ADDR
    always_comb begin
        s_arid     = grant_q ? m1_arid    : m0_arid;
        s_araddr   = grant_q ? m1_araddr  : m0_araddr;
        s_arlen    = grant_q ? m1_arlen   : m0_arlen;
        s_arsize   = grant_q ? m1_arsize  : m0_arsize;
        s_arburst  = grant_q ? m1_arburst : m0_arburst;
        s_aruser   = grant_q ? m1_aruser  : m0_aruser;
        s_arvalid  = in_addr & gnt_arvalid;
        m0_arready = in_addr & ~grant_q & s_arready;
        m1_arready = in_addr &  grant_q & s_arready;
    end

    // R path: slave response routed to the owner in DATA; the other master sees zeros
    always_comb begin
        s_rready  = in_data & gnt_rready;
        m0_rvalid = in_data & ~grant_q & s_rvalid;
        m1_rvalid = in_data &  grant_q & s_rvalid;
        m0_rid    = '0;
        m0_rdata  = '0;
        m0_rresp  = '0;
        m0_rlast  = 1'b0;
        m0_ruser  = '0;
        m1_rid    = '0;
        m1_rdata  = '0;
        m1_rresp  = '0;
        m1_rlast  = 1'b0;
        m1_ruser  = '0;
        if (in_data && !grant_q) begin
            m0_rid   = s_rid;
            m0_rdata = s_rdata;
            m0_rresp = s_rresp;
            m0_rlast = s_rlast;
            m0_ruser = s_ruser;
        end
        if (in_data && grant_q) begin
            m1_rid   = s_rid;
            m1_rdata = s_rdata;
            m1_rresp = s_rresp;
            m1_rlast = s_rlast;
            m1_ruser = s_ruser;
        end
    end

    // Arbitration FSM with beat counting and sticky length-error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            len_err_q    <= 1'b0;
            len_q        <= '0;
            beat_cnt_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (m0_arvalid || m1_arvalid) begin
                        grant_q <= pick;
                        state_q <= StAddr;
                    end
                end
                StAddr: begin
                    // Owner withdrew its request before the handshake: re-arbitrate
                    if (!gnt_arvalid) begin
                        state_q <= StIdle;
                    end else if (s_arready) begin
                        len_q      <= s_arlen;
                        beat_cnt_q <= '0;
                        state_q    <= StData;
                    end
                end
                StData: begin
                    if (r_hs) begin
                        if (beat_cnt_q != '1) begin
                            beat_cnt_q <= beat_cnt_q + 1'b1;
                        end
                        if (s_rlast) begin
                            if (!at_len) begin
                                len_err_q <= 1'b1;
                            end
                            last_grant_q <= grant_q;
                            state_q      <= StIdle;
                        end else if (at_len) begin
                            // Final beat per arlen arrived without rlast; keep draining
                            len_err_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_rd_arb.sv
// Randomized bench for axi_rd_arb: a slave model serves bursts, a transaction-level
// reference model predicts service order, beat data, routing and the length-error flag.
module tb_axi_rd_arb;
    import axi_rd_arb_pkg::*;

    localparam int ID_W   = AxiIdWidth;
    localparam int ADDR_W = AxiAddrWidth;
    localparam int DATA_W = AxiDataWidth;
    localparam int USER_W = AxiUserWidth;

    logic clk = 1'b0;
    logic rst;
    logic [ID_W-1:0]   m0_arid, m1_arid, s_arid, m0_rid, m1_rid, s_rid;
    logic [ADDR_W-1:0] m0_araddr, m1_araddr, s_araddr;
    logic [7:0]        m0_arlen, m1_arlen, s_arlen;
    logic [2:0]        m0_arsize, m1_arsize, s_arsize;
    logic [1:0]        m0_arburst, m1_arburst, s_arburst;
    logic [USER_W-1:0] m0_aruser, m1_aruser, s_aruser, m0_ruser, m1_ruser, s_ruser;
    logic              m0_arvalid, m1_arvalid, s_arvalid, m0_arready, m1_arready, s_arready;
    logic [DATA_W-1:0] m0_rdata, m1_rdata, s_rdata;
    logic [1:0]        m0_rresp, m1_rresp, s_rresp;
    logic              m0_rlast, m1_rlast, s_rlast;
    logic              m0_rvalid, m1_rvalid, s_rvalid, m0_rready, m1_rready, s_rready;
    logic              grant, busy, len_err;

    always #5 clk = ~clk;

    axi_rd_arb dut (
        .clk(clk), .rst(rst),
        .m0_arid(m0_arid), .m0_araddr(m0_araddr), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize),
        .m0_arburst(m0_arburst), .m0_aruser(m0_aruser), .m0_arvalid(m0_arvalid),
        .m0_arready(m0_arready), .m0_rid(m0_rid), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp),
        .m0_rlast(m0_rlast), .m0_ruser(m0_ruser), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
        .m1_arid(m1_arid), .m1_araddr(m1_araddr), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize),
        .m1_arburst(m1_arburst), .m1_aruser(m1_aruser), .m1_arvalid(m1_arvalid),
        .m1_arready(m1_arready), .m1_rid(m1_rid), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp),
        .m1_rlast(m1_rlast), .m1_ruser(m1_ruser), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arburst(s_arburst), .s_aruser(s_aruser), .s_arvalid(s_arvalid),
        .s_arready(s_arready), .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .s_rlast(s_rlast), .s_ruser(s_ruser), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .grant(grant), .busy(busy), .len_err(len_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic finish_test();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    endtask

    function automatic logic [DATA_W-1:0] beat_data(input logic [ADDR_W-1:0] a, input int b);
        logic [7:0] lo;
        lo = 8'hA0 + 8'(b);
        return {a[23:0], lo};
    endfunction

    // master-side request bookkeeping
    logic [ID_W-1:0]   req_id[2];
    logic [ADDR_W-1:0] req_addr[2];
    logic [7:0]        req_len[2];
    int                rx_cnt[2];
    // slave model
    bit                sl_active;
    int                sl_beat, sl_plan;
    logic [ADDR_W-1:0] sl_addr;
    logic [ID_W-1:0]   sl_id;
    logic [7:0]        sl_len;
    int                plan_override, ar_stall;
    bit                toggle_mode;
    // reference model and cross-cycle tracking
    bit                model_last;
    bit                exp_len_err;
    int                cur_owner;
    bit                owner_done;
    int                done_plan;
    bit                last_hs_prev, stall_prev;
    logic [ADDR_W-1:0] prev_araddr;
    logic [7:0]        prev_arlen;

    task automatic tick();
        logic ar_hs, r_hs, sarv, exp_last;
        logic own_arready, own_rvalid, own_rready, own_rlast, oth_arready, oth_rvalid;
        logic [ID_W-1:0]   own_rid, cap_id;
        logic [DATA_W-1:0] own_rdata, oth_rdata;
        logic [ADDR_W-1:0] cap_addr;
        logic [7:0]        cap_len;
        int o;
        @(negedge clk);
        o = cur_owner;
        if (last_hs_prev) check_eq("busy_after_rlast", 64'(busy), 64'(0));
        if (stall_prev) begin
            check_eq("ar_hold_addr", 64'(s_araddr), 64'(prev_araddr));
            check_eq("ar_hold_len", 64'(s_arlen), 64'(prev_arlen));
            check_eq("ar_hold_valid", 64'(s_arvalid), 64'(1));
        end
        ar_hs    = s_arvalid & s_arready;
        r_hs     = s_rvalid & s_rready;
        sarv     = s_arvalid;
        exp_last = (sl_beat == sl_plan - 1);
        cap_addr = s_araddr;
        cap_len  = s_arlen;
        cap_id   = s_arid;
        if (o >= 0) begin
            own_arready = (o == 1) ? m1_arready : m0_arready;
            own_rvalid  = (o == 1) ? m1_rvalid  : m0_rvalid;
            own_rready  = (o == 1) ? m1_rready  : m0_rready;
            own_rlast   = (o == 1) ? m1_rlast   : m0_rlast;
            own_rid     = (o == 1) ? m1_rid     : m0_rid;
            own_rdata   = (o == 1) ? m1_rdata   : m0_rdata;
            oth_arready = (o == 1) ? m0_arready : m1_arready;
            oth_rvalid  = (o == 1) ? m0_rvalid  : m1_rvalid;
            oth_rdata   = (o == 1) ? m0_rdata   : m1_rdata;
            if (busy) check_eq("grant", 64'(grant), 64'(o));
            check_eq("other_rvalid", 64'(oth_rvalid), 64'(0));
            check_eq("other_arready", 64'(oth_arready), 64'(0));
            check_eq("other_rdata", 64'(oth_rdata), 64'(0));
            if (s_arvalid) check_eq("arready_pass", 64'(own_arready), 64'(s_arready));
            if (s_rvalid) check_eq("rready_mirror", 64'(s_rready), 64'(own_rready));
            if (ar_hs) begin
                check_eq("ar_addr", 64'(s_araddr), 64'(req_addr[o]));
                check_eq("ar_len", 64'(s_arlen), 64'(req_len[o]));
                check_eq("ar_id", 64'(s_arid), 64'(req_id[o]));
            end
            if (r_hs) begin
                check_eq("r_valid", 64'(own_rvalid), 64'(1));
                check_eq("r_data", 64'(own_rdata), 64'(beat_data(req_addr[o], rx_cnt[o])));
                check_eq("r_id", 64'(own_rid), 64'(req_id[o]));
                check_eq("r_last", 64'(own_rlast), 64'(exp_last));
            end
        end
        stall_prev   = s_arvalid & ~s_arready;
        prev_araddr  = s_araddr;
        prev_arlen   = s_arlen;
        last_hs_prev = r_hs & exp_last;

        @(posedge clk);
        #1;
        if (ar_hs) begin
            if (o == 1) m1_arvalid = 1'b0;
            else m0_arvalid = 1'b0;
            sl_active = 1'b1;
            sl_beat   = 0;
            sl_addr   = cap_addr;
            sl_len    = cap_len;
            sl_id     = cap_id;
            sl_plan   = (plan_override > 0) ? plan_override : int'(cap_len) + 1;
            plan_override = 0;
        end
        if (r_hs) begin
            if (o >= 0) rx_cnt[o]++;
            sl_beat++;
            if (exp_last) begin
                exp_len_err = exp_len_err | (sl_plan != int'(sl_len) + 1);
                sl_active   = 1'b0;
                owner_done  = 1'b1;
                done_plan   = sl_plan;
            end
        end
        if (ar_stall > 0) begin
            s_arready = 1'b0;
            if (sarv) ar_stall--;
        end else begin
            s_arready = ($urandom_range(0, 2) != 0);
        end
        if (sl_active) begin
            if (!s_rvalid || r_hs) s_rvalid = ($urandom_range(0, 3) != 0);
            s_rdata = beat_data(sl_addr, sl_beat);
            s_rlast = (sl_beat == sl_plan - 1);
            s_rid   = sl_id;
            s_rresp = AxiRespOkay;
            s_ruser = sl_id;
        end else begin
            s_rvalid = 1'b0;
            s_rlast  = 1'b0;
        end
        if (toggle_mode) begin
            m0_rready = ~m0_rready;
            m1_rready = ~m1_rready;
        end else begin
            m0_rready = 1'($urandom_range(0, 1));
            m1_rready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic raise_req(input int i, input int len);
        req_id[i]   = ID_W'($urandom);
        req_addr[i] = ADDR_W'($urandom);
        req_len[i]  = 8'(len);
        rx_cnt[i]   = 0;
        if (i == 0) begin
            m0_arid = req_id[0]; m0_araddr = req_addr[0]; m0_arlen = req_len[0];
            m0_arsize = 3'd2; m0_arburst = 2'b01; m0_aruser = '0; m0_arvalid = 1'b1;
        end else begin
            m1_arid = req_id[1]; m1_araddr = req_addr[1]; m1_arlen = req_len[1];
            m1_arsize = 3'd2; m1_arburst = 2'b01; m1_aruser = '1; m1_arvalid = 1'b1;
        end
    endtask

    task automatic run_round(input bit w0, input bit w1, input int len0, input int len1,
                             input int plan_ovr, input int stall, input bit tog);
        int order[$];
        int first, n;
        plan_override = plan_ovr;
        ar_stall      = stall;
        toggle_mode   = tog;
        if (w0 && w1) begin
            first = model_last ? 0 : 1;
            order.push_back(first);
            order.push_back(1 - first);
            model_last = (first == 0);
        end else begin
            first = w1 ? 1 : 0;
            order.push_back(first);
            model_last = (first == 1);
        end
        if (w0) raise_req(0, len0);
        if (w1) raise_req(1, len1);
        foreach (order[k]) begin
            cur_owner  = order[k];
            owner_done = 1'b0;
            n = 0;
            while (!owner_done) begin
                if (n >= 400) begin
                    check_eq("timeout", 64'(0), 64'(1));
                    finish_test();
                end
                tick();
                n++;
            end
            check_eq("beat_count", 64'(rx_cnt[order[k]]), 64'(done_plan));
        end
        cur_owner = -1;
        tick();
        check_eq("len_err", 64'(len_err), 64'(exp_len_err));
        toggle_mode = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        {m0_arid, m0_araddr, m0_arlen, m0_arsize, m0_arburst, m0_aruser, m0_arvalid} = '0;
        {m1_arid, m1_araddr, m1_arlen, m1_arsize, m1_arburst, m1_aruser, m1_arvalid} = '0;
        m0_rready = 1'b0; m1_rready = 1'b1;
        s_arready = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0;
        s_rid = '0; s_rdata = '0; s_rresp = '0; s_ruser = '0;
        sl_active = 1'b0; sl_beat = 0; sl_plan = 0; sl_len = '0; sl_addr = '0; sl_id = '0;
        plan_override = 0; ar_stall = 0; toggle_mode = 1'b0;
        model_last = 1'b1; exp_len_err = 1'b0; cur_owner = -1; owner_done = 1'b0;
        done_plan = 0; last_hs_prev = 1'b0; stall_prev = 1'b0;
        prev_araddr = '0; prev_arlen = '0;
        rx_cnt[0] = 0; rx_cnt[1] = 0;

        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", 64'(busy), 64'(0));
        check_eq("rst_grant", 64'(grant), 64'(0));
        check_eq("rst_len_err", 64'(len_err), 64'(0));
        check_eq("rst_valids", 64'({s_arvalid, s_rready, m0_arready, m1_arready,
                                    m0_rvalid, m1_rvalid}), 64'(0));
        rst = 1'b0;

        // ties alternate starting with M0
        run_round(1, 1, 3, 2, 0, 0, 0);
        run_round(1, 1, 1, 4, 0, 0, 0);
        run_round(1, 1, 0, 0, 0, 0, 0);
        // M0 alone, arlen 3, slave stalls the address phase
        run_round(1, 0, 3, 0, 0, 5, 0);
        // M1 alone, arlen 7, rready toggling
        run_round(0, 1, 0, 7, 0, 0, 1);
        // early rlast on beat 2 of an arlen=3 burst
        run_round(1, 0, 3, 0, 2, 0, 0);
        check_eq("len_err_set", 64'(len_err), 64'(1));
        run_round(1, 1, 2, 5, 0, 0, 0);

        for (int r = 0; r < 24; r++) begin
            int w, l0, l1, po;
            w  = $urandom_range(1, 3);
            l0 = $urandom_range(0, 15);
            l1 = $urandom_range(0, 15);
            po = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 18) : 0;
            run_round(w[0], w[1], l0, l1, po, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        // reset in the middle of a burst
        cur_owner = 0;
        raise_req(0, 3);
        n = 0;
        while (rx_cnt[0] < 1) begin
            if (n >= 400) begin
                check_eq("timeout_rst", 64'(0), 64'(1));
                finish_test();
            end
            tick();
            n++;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("mid_rst_busy", 64'(busy), 64'(0));
        check_eq("mid_rst_grant", 64'(grant), 64'(0));
        check_eq("mid_rst_len_err", 64'(len_err), 64'(0));
        check_eq("mid_rst_valids", 64'({s_arvalid, s_rready, m0_arready, m1_arready,
                                        m0_rvalid, m1_rvalid}), 64'(0));
        rst = 1'b0;
        m0_arvalid = 1'b0; m1_arvalid = 1'b0;
        sl_active = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0; sl_beat = 0; sl_plan = 0;
        model_last = 1'b1; exp_len_err = 1'b0; cur_owner = -1;
        last_hs_prev = 1'b0; stall_prev = 1'b0; plan_override = 0; ar_stall = 0;

        run_round(1, 1, 3, 2, 0, 0, 0);
        run_round(0, 1, 0, 6, 0, 2, 0);
        finish_test();
    end

endmodule
